// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM encodings for the FIFO UART.
// No logic; no latency or flow-control of its own.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [7:0] REG_DIV_LO = 8'd0;
  localparam logic [7:0] REG_DIV_HI = 8'd1;
  localparam logic [7:0] REG_STATUS = 8'd2;
  localparam logic [7:0] REG_DATA   = 8'd3;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_NONFULL  = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_OVERRUN     = 3;
  localparam int ST_FRAME_ERR   = 4;
  localparam int ST_PARITY_ERR  = 5;
  localparam int CTL_PARITY_EN  = 6;
  localparam int CTL_PARITY_ODD = 7;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_SHIFT, TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO; rdata reflects the head entry combinationally, pointer update next edge.
// Push is dropped when full unless a pop lands in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART with 16x oversampled RX/TX, parity, sticky errors and RX/TX FIFOs.
// Read data one cycle after r_en; full TX FIFO drops writes, full RX FIFO drops frames and flags overrun.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] address,
  input  logic [7:0] din,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam logic [3:0] TCNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TCNT_HALF = 4'(OVERSAMPLE / 2 - 1);

  logic [7:0] offset;
  logic       wr_div_lo, wr_div_hi, wr_stat, wr_data, rd_data;

  assign offset    = address - BASE_ADDRESS;
  assign wr_div_lo = w_en && (offset == REG_DIV_LO);
  assign wr_div_hi = w_en && (offset == REG_DIV_HI);
  assign wr_stat   = w_en && (offset == REG_STATUS);
  assign wr_data   = w_en && (offset == REG_DATA);
  assign rd_data   = r_en && (offset == REG_DATA);

  logic [15:0] div_q, div_d, pre_q, pre_d;
  logic        tick;
  logic        par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic        ovr_q, ovr_d, frm_q, frm_d, perr_q, perr_d;
  logic        set_ovr, set_frm, set_perr;
  logic [7:0]  dout_q, dout_d, status, rx_byte;
  logic        irq_q;

  logic                 rx_push, rx_full, rx_empty, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] rx_rdata, tx_rdata;

  rx_state_e            rx_st_q, rx_st_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d, rx_bits_q, rx_bits_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_s1_q, rx_s2_q, rx_mid;

  tx_state_e            tx_st_q, tx_st_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d, tx_left_q, tx_left_d;
  logic [DATA_BITS:0]   tx_sh_q, tx_sh_d, tx_frame;
  logic                 tx_q, tx_d, tx_mid;

  // Prescaler wraps at the divisor; any divisor write restarts it.
  assign tick = (pre_q == div_q);

  always_comb begin
    div_d = div_q;
    if (wr_div_lo) div_d[7:0]  = din;
    if (wr_div_hi) div_d[15:8] = din;
    pre_d = (tick || wr_div_lo || wr_div_hi) ? 16'd0 : pre_q + 16'd1;
  end

  always_comb begin
    par_en_d  = wr_stat ? din[CTL_PARITY_EN]  : par_en_q;
    par_odd_d = wr_stat ? din[CTL_PARITY_ODD] : par_odd_q;
    ovr_d  = (ovr_q  & ~(wr_stat & din[ST_OVERRUN]))   | set_ovr;
    frm_d  = (frm_q  & ~(wr_stat & din[ST_FRAME_ERR]))  | set_frm;
    perr_d = (perr_q & ~(wr_stat & din[ST_PARITY_ERR])) | set_perr;
  end

  always_comb begin
    status                 = '0;
    status[ST_RX_NONEMPTY] = !rx_empty;
    status[ST_TX_NONFULL]  = !tx_full;
    status[ST_TX_IDLE]     = tx_empty && (tx_st_q == TX_IDLE);
    status[ST_OVERRUN]     = ovr_q;
    status[ST_FRAME_ERR]   = frm_q;
    status[ST_PARITY_ERR]  = perr_q;
    status[CTL_PARITY_EN]  = par_en_q;
    status[CTL_PARITY_ODD] = par_odd_q;
    rx_byte                = '0;
    rx_byte[DATA_BITS-1:0] = rx_rdata;
  end

  always_comb begin
    dout_d = dout_q;
    if (r_en) begin
      case (offset)
        REG_DIV_LO: dout_d = div_q[7:0];
        REG_DIV_HI: dout_d = div_q[15:8];
        REG_STATUS: dout_d = status;
        REG_DATA:   dout_d = rx_empty ? 8'h00 : rx_byte;
        default:    dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
      perr_q    <= 1'b0;
      dout_q    <= '0;
      irq_q     <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
    end else begin
      div_q     <= div_d;
      pre_q     <= pre_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
      perr_q    <= perr_d;
      dout_q    <= dout_d;
      irq_q     <= !rx_empty | ovr_q | frm_q | perr_q;
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rd_data), .wdata(rx_sh_q),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(wr_data), .pop(tx_pop), .wdata(din[DATA_BITS-1:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- RX ----------------
  assign rx_mid = tick && (rx_tcnt_q == TCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q   <= RX_IDLE;
      rx_tcnt_q <= '0;
      rx_bits_q <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_tcnt_q <= rx_tcnt_d;
      rx_bits_q <= rx_bits_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_tcnt_d = tick ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
    rx_bits_d = rx_bits_q;
    rx_sh_d   = rx_sh_q;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (tick && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (tick && rx_tcnt_q == TCNT_HALF) begin
          rx_tcnt_d = '0;
          rx_bits_d = '0;
          rx_st_d   = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_sh_d   = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_bits_d = rx_bits_q + 4'd1;
          if (rx_bits_q == 4'(DATA_BITS - 1)) rx_st_d = par_en_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: if (rx_mid) rx_st_d = RX_STOP;
      RX_STOP:   if (rx_mid) rx_st_d = rx_s2_q ? RX_IDLE : RX_BREAK;
      RX_BREAK: begin
        rx_tcnt_d = '0;
        if (tick && rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // A bus pop in the same cycle frees a slot in a full RX FIFO.
  always_comb begin
    rx_push  = (rx_st_q == RX_STOP) && rx_mid && rx_s2_q && (!rx_full || rd_data);
    set_ovr  = (rx_st_q == RX_STOP) && rx_mid && rx_s2_q && rx_full && !rd_data;
    set_frm  = (rx_st_q == RX_STOP) && rx_mid && !rx_s2_q;
    set_perr = (rx_st_q == RX_PARITY) && rx_mid && (rx_s2_q != ((^rx_sh_q) ^ par_odd_q));
  end

  // ---------------- TX ----------------
  assign tx_mid   = tick && (tx_tcnt_q == TCNT_LAST);
  assign tx_frame = {(^tx_rdata) ^ par_odd_q, tx_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= TX_IDLE;
      tx_tcnt_q <= '0;
      tx_left_q <= '0;
      tx_sh_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_tcnt_q <= tx_tcnt_d;
      tx_left_q <= tx_left_d;
      tx_sh_q   <= tx_sh_d;
      tx_q      <= tx_d;
    end
  end

  // Parity settings are captured into the shift count and frame at pop time.
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_tcnt_d = tick ? tx_tcnt_q + 4'd1 : tx_tcnt_q;
    tx_left_d = tx_left_q;
    tx_sh_d   = tx_sh_q;
    tx_d      = tx_q;
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_tcnt_d = '0;
        if (tick && !tx_empty) begin
          tx_st_d   = TX_SHIFT;
          tx_d      = 1'b0;
          tx_sh_d   = tx_frame;
          tx_left_d = par_en_q ? 4'(DATA_BITS + 1) : 4'(DATA_BITS);
        end
      end
      TX_SHIFT: begin
        if (tx_mid) begin
          if (tx_left_q != 4'd0) begin
            tx_d      = tx_sh_q[0];
            tx_sh_d   = tx_sh_q >> 1;
            tx_left_d = tx_left_q - 4'd1;
          end else begin
            tx_d    = 1'b1;
            tx_st_d = TX_STOP;
          end
        end
      end
      TX_STOP: if (tx_mid) tx_st_d = TX_IDLE;
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = (tx_st_q == TX_IDLE) && tick && !tx_empty;
  end

  assign tx   = tx_q;
  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scenario bench for uart_fifo_ctrl: bus register access, TX framing, loopback, RX error paths.
module tb_uart_fifo_ctrl;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk, rst_n, w_en, r_en, rx_bfm, loop_en, tx_w, irq_w, rx_line;
  logic [7:0] address, din, dout_w;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  logic       bit_q [$];

  assign rx_line = loop_en ? tx_w : rx_bfm;

  uart_fifo_ctrl #(.BASE_ADDRESS(BASE), .FIFO_DEPTH(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .din(din), .w_en(w_en), .r_en(r_en),
    .dout(dout_w), .rx(rx_line), .tx(tx_w), .irq(irq_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] off, input logic [7:0] d);
    @(negedge clk);
    address = BASE + off; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [7:0] d);
    @(negedge clk);
    address = BASE + off; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = dout_w;
  endtask

  task automatic wait_status(input int bitn, input int max_reads, output bit ok);
    logic [7:0] s;
    ok = 1'b0;
    for (int i = 0; i < max_reads && !ok; i++) begin
      bus_read(8'd2, s);
      if (s[bitn] === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_on, input logic par_bit,
                            input logic stop_bit, input int bclk);
    rx_bfm = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_bfm = d[i];
      repeat (bclk) @(negedge clk);
    end
    if (par_on) begin
      rx_bfm = par_bit;
      repeat (bclk) @(negedge clk);
    end
    rx_bfm = stop_bit;
    repeat (bclk) @(negedge clk);
    rx_bfm = 1'b1;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (dout_w !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout_w); end
    n_cmp++; if (tx_w !== 1'b1)    begin n_err++; $display("FAIL reset_tx got %b want 1", tx_w); end
    n_cmp++; if (irq_w !== 1'b0)   begin n_err++; $display("FAIL reset_irq got %b want 0", irq_w); end
    rst_n = 1'b1;
    bus_write(8'd4, 8'hFF);
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h06) begin n_err++; $display("FAIL reset_status got %h want 06", r); end
    repeat (3) @(negedge clk);
    n_cmp++; if (dout_w !== 8'h06) begin n_err++; $display("FAIL dout_hold got %h want 06", dout_w); end
    bus_read(8'd0, r);
    n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_div_lo got %h want 00", r); end
    bus_read(8'd4, r);
    n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL unmapped_read got %h want 00", r); end
  endtask

  task automatic test_tx_frame;
    logic [7:0] r, d;
    bit found;
    int cnt;
    logic b;
    d = 8'hA5;
    bus_write(8'd0, 8'd3);
    bus_write(8'd1, 8'd0);
    bus_read(8'd0, r);
    n_cmp++; if (r !== 8'h03) begin n_err++; $display("FAIL div_lo_rb got %h want 03", r); end
    bus_read(8'd1, r);
    n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL div_hi_rb got %h want 00", r); end
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    bit_q.push_back(1'b1);
    bus_write(8'd3, d);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_w === 1'b0) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL tx_start_timeout got none want start within 50 clk"); end
    if (found) begin
      cnt = 0;
      while (tx_w === 1'b0 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      n_cmp++; if (cnt != 64) begin n_err++; $display("FAIL tx_start_len got %0d want 64", cnt); end
      repeat (32) @(negedge clk);
      for (int i = 1; i <= 9; i++) begin
        b = bit_q.pop_front();
        n_cmp++; if (tx_w !== b) begin n_err++; $display("FAIL tx_bit%0d got %b want %b", i, tx_w, b); end
        if (i == 1) begin
          bus_read(8'd2, r);
          n_cmp++; if (r !== 8'h02) begin n_err++; $display("FAIL tx_busy_status got %h want 02", r); end
          repeat (62) @(negedge clk);
        end else if (i < 9) begin
          repeat (64) @(negedge clk);
        end
      end
      repeat (40) @(negedge clk);
      bus_read(8'd2, r);
      n_cmp++; if (r !== 8'h06) begin n_err++; $display("FAIL tx_idle_status got %h want 06", r); end
    end
    bit_q.delete();
  endtask

  task automatic test_loopback_parity;
    logic [7:0] r, e;
    bit ok;
    bus_write(8'd0, 8'd1);
    bus_write(8'd2, 8'hC0);
    loop_en = 1'b1;
    exp_q.push_back(8'h3C);
    bus_write(8'd3, 8'h3C);
    wait_status(0, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL loop_rx_timeout got empty want rx_nonempty"); end
    @(negedge clk);
    n_cmp++; if (irq_w !== 1'b1) begin n_err++; $display("FAIL loop_irq_set got %b want 1", irq_w); end
    bus_read(8'd2, r);
    n_cmp++; if ((r & 8'h38) !== 8'h00) begin n_err++; $display("FAIL loop_flags got %h want 00", r & 8'h38); end
    bus_read(8'd3, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL loop_data got %h want %h", r, e); end
    @(negedge clk);
    n_cmp++; if (irq_w !== 1'b0) begin n_err++; $display("FAIL loop_irq_clear got %b want 0", irq_w); end
    wait_status(2, 300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL loop_tx_idle_timeout got busy want idle"); end
    loop_en = 1'b0;
  endtask

  task automatic test_parity_err;
    logic [7:0] r, e;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 32);
    repeat (4) @(negedge clk);
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'hE7) begin n_err++; $display("FAIL perr_status got %h want e7", r); end
    n_cmp++; if (irq_w !== 1'b1) begin n_err++; $display("FAIL perr_irq got %b want 1", irq_w); end
    bus_read(8'd3, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL perr_data got %h want %h", r, e); end
    repeat (2) @(negedge clk);
    n_cmp++; if (irq_w !== 1'b1) begin n_err++; $display("FAIL perr_irq_sticky got %b want 1", irq_w); end
    bus_write(8'd2, 8'h20);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq_w !== 1'b0) begin n_err++; $display("FAIL perr_irq_clear got %b want 0", irq_w); end
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h06) begin n_err++; $display("FAIL perr_cleared got %h want 06", r); end
  endtask

  task automatic test_overrun;
    logic [7:0] r, e;
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(bytes[i]);
      send_frame(bytes[i], 1'b0, 1'b0, 1'b1, 32);
    end
    repeat (4) @(negedge clk);
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h0F) begin n_err++; $display("FAIL ovr_status got %h want 0f", r); end
    n_cmp++; if (irq_w !== 1'b1) begin n_err++; $display("FAIL ovr_irq got %b want 1", irq_w); end
    for (int i = 0; i < 4; i++) begin
      bus_read(8'd3, r);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e) begin n_err++; $display("FAIL ovr_data%0d got %h want %h", i, r, e); end
    end
    bus_read(8'd3, r);
    n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL empty_read got %h want 00", r); end
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h0E) begin n_err++; $display("FAIL ovr_drained got %h want 0e", r); end
    bus_write(8'd2, 8'h08);
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h06) begin n_err++; $display("FAIL ovr_cleared got %h want 06", r); end
  endtask

  task automatic test_frame_err;
    logic [7:0] r, e;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 32);
    repeat (4) @(negedge clk);
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h16) begin n_err++; $display("FAIL ferr_status got %h want 16", r); end
    n_cmp++; if (irq_w !== 1'b1) begin n_err++; $display("FAIL ferr_irq got %b want 1", irq_w); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 32);
    repeat (4) @(negedge clk);
    bus_read(8'd3, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL ferr_recover got %h want %h", r, e); end
    bus_write(8'd2, 8'h10);
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h06) begin n_err++; $display("FAIL ferr_cleared got %h want 06", r); end
  endtask

  task automatic test_glitch;
    logic [7:0] r;
    bus_write(8'd0, 8'd15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_bfm = 1'b0;
      @(negedge clk); rx_bfm = 1'b1;
      repeat (300) @(negedge clk);
    end
    bus_read(8'd2, r);
    n_cmp++; if (r !== 8'h06) begin n_err++; $display("FAIL glitch_status got %h want 06", r); end
    n_cmp++; if (irq_w !== 1'b0) begin n_err++; $display("FAIL glitch_irq got %b want 0", irq_w); end
  endtask

  initial begin
    rst_n = 1'b0; address = '0; din = '0; w_en = 1'b0; r_en = 1'b0;
    rx_bfm = 1'b1; loop_en = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback_parity();
    test_parity_err();
    test_overrun();
    test_frame_err();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Second-generation memory-mapped UART for the 8-bit I/O bus.
- Adds a 16-bit baud divisor, configurable data width, optional parity, and parametrised RX/TX FIFOs.
- Adds sticky error flags (overrun, frame, parity).
- Sits on the same address/din/dout/w_en/r_en peripheral bus as the other SoC I/O blocks.

Parameters:
- BASE_ADDRESS, 8'h00, first of four consecutive register addresses.
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..64.
- DATA_BITS, 8, frame data width, 5..8; unused upper bits read 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- address  input  8  bus address.
- din  input  8  write data.
- w_en  input  1  write strobe, one cycle per access.
- r_en  input  1  read strobe, one cycle per access.
- dout  output  8  registered read data.
- rx  input  1  serial in, idle high.
- tx  output  1  serial out, idle high.
- irq  output  1  level interrupt, registered.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: dout=0, tx=1, irq=0.
  - Divisor=0; FIFOs empty; FSMs idle; all flags 0; control bits 0.
- Register map:
  - BASE+0: divisor[7:0], RW.
  - BASE+1: divisor[15:8], RW.
  - BASE+2: status/control.
    - bit0 rx_nonempty, RO.
    - bit1 tx_nonfull, RO.
    - bit2 tx_idle, RO: TX FIFO empty and shifter idle.
    - bit3 overrun, sticky, write-1-to-clear.
    - bit4 frame_err, sticky, W1C.
    - bit5 parity_err, sticky, W1C.
    - bit6 parity_en, RW.
    - bit7 parity_odd, RW.
  - BASE+3: write pushes TX FIFO; read pops RX FIFO.
  - Any other address: no write effect; read returns 0.
- Read latency: dout is valid the cycle after r_en and holds until the next read.
- Reading BASE+3 when RX is empty returns 0 and pops nothing.
- Writing BASE+3 when TX is full drops the byte; no flag is set.
- Tick: 16-bit prescaler counts 0..divisor and pulses tick for one clk on wrap. Divisor=0 gives a tick every clk. Writing either divisor byte resets the prescaler to 0.
- RX path:
  - rx passes through a 2-flop synchroniser on clk (not tick-gated).
  - IDLE: on a low sample at tick, go to START.
  - START: after 8 ticks, re-sample. If high (glitch), return to IDLE; else go to DATA.
  - DATA: sample every 16 ticks, LSB first, for DATA_BITS bits. Then go to PARITY if parity_en, else STOP.
  - PARITY: sample after 16 ticks and compare to computed parity (even when parity_odd=0). Mismatch sets parity_err; the byte is still pushed.
  - STOP: sample after 16 ticks.
    - High and RX not full: push the byte.
    - High and RX full: discard the byte and set overrun.
    - Low: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for a high sample, then go to IDLE.
- TX path:
  - IDLE: at tick, if the TX FIFO is non-empty, pop it, drive tx=0 (start), go to SHIFT.
  - SHIFT: each bit lasts 16 ticks; DATA_BITS data bits LSB first, then a parity bit if enabled, then stop=1 for 16 ticks, then IDLE.
  - parity_en/parity_odd are latched at frame start; mid-frame changes affect only the next frame.
- Simultaneous events:
  - Same-cycle push and pop on one FIFO is legal even when full or empty. Count stays the same if both actions take effect.
  - Same-cycle W1C write and hardware set of the same flag: the set wins.
  - Same-cycle bus pop of the last RX entry and an RX push: rx_nonempty stays 1.
- irq = rx_nonempty | overrun | frame_err | parity_err, registered.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty; wrap is natural.

Decomposition:
- Package uart_pkg:
  - register offset constants.
  - status bit indices.
  - RX state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - TX state enum: IDLE, SHIFT, STOP.
  - OVERSAMPLE=16 constant.
- Sub-module sync_fifo (WIDTH, DEPTH): push, pop, wdata, rdata (show-ahead), full, empty. Instantiated twice.

Test Plan:
- Reset then read BASE+2: dout=8'h06 (tx_nonfull, tx_idle); tx=1; irq=0.
- Divisor=3, 8N1, write 8'hA5 to BASE+3: tx frame is 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; afterwards tx_idle=1.
- Loop tx to rx, divisor=1, parity_en=1, parity_odd=1, send 8'h3C: read BASE+3 returns 8'h3C; parity_err=0; irq falls after the pop.
- Inject 8'h55 with even parity while odd is configured: byte received; parity_err=1; irq=1. Write 8'h20 to BASE+2 to clear; irq drops.
- FIFO_DEPTH=4, receive 5 frames without reading: first 4 read back in order; overrun=1; the fifth read returns 0.
- Stop bit forced low: frame_err=1, nothing pushed. A 1-clk low glitch on idle rx (divisor=15) receives nothing.
